// File: rtl/wave_fetch_responder.sv
// Wave-fetch responder: serves sample-player byte requests from a one-word cache,
// falling back to a 16-bit SDRAM read with timeout, bounded retry and abandon.
module wave_fetch_responder #(
    parameter int ADDR_W  = 25,
    parameter int TIMEOUT = 31,
    parameter int RETRIES = 3
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              dl_active,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic [7:0]        rsp_byte,
    output logic              rsp_err,
    output logic              busy,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [15:0]       mem_dout,
    output logic [1:0]        dbg_state
);

    // Handshake: req is a level held until the one-cycle rsp_valid pulse; the
    // block then waits in DONE for req to drop before accepting another request.
    // mem_rd is a one-cycle strobe, mem_ready a one-cycle reply, only honoured in WAIT.

    localparam int TAG_W = ADDR_W - 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RTY_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [RTY_W-1:0] RETRIES_C = RTY_W'(RETRIES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q,       state_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic [RTY_W-1:0]  rty_q,         rty_d;
    logic              sel_q,         sel_d;
    logic              cache_valid_q, cache_valid_d;
    logic [TAG_W-1:0]  tag_q,         tag_d;
    logic [15:0]       word_q,        word_d;
    logic              rsp_valid_q,   rsp_valid_d;
    logic              rsp_err_q,     rsp_err_d;
    logic [7:0]        rsp_byte_q,    rsp_byte_d;
    logic              mem_rd_q,      mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic              busy_q,        busy_d;

    logic              hit;

    assign hit = cache_valid_q && (req_addr[ADDR_W-1:1] == tag_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rty_d         = rty_q;
        sel_d         = sel_q;
        cache_valid_d = cache_valid_q;
        tag_d         = tag_q;
        word_d        = word_q;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_byte_d    = rsp_byte_q;
        mem_rd_d      = 1'b0;
        mem_addr_d    = mem_addr_q;

        if (dl_active) begin
            // The SDRAM belongs to the download path: drop everything, forget the word.
            state_d       = S_IDLE;
            cache_valid_d = 1'b0;
            cnt_d         = '0;
            rty_d         = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        sel_d = req_addr[0];
                        if (hit) begin
                            rsp_valid_d = 1'b1;
                            rsp_byte_d  = req_addr[0] ? word_q[15:8] : word_q[7:0];
                            state_d     = S_DONE;
                        end else begin
                            mem_rd_d   = 1'b1;
                            mem_addr_d = {req_addr[ADDR_W-1:1], 1'b0};
                            cnt_d      = '0;
                            rty_d      = '0;
                            state_d    = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A reply in the expiry cycle still counts as a normal response.
                    if (mem_ready) begin
                        word_d        = mem_dout;
                        tag_d         = mem_addr_q[ADDR_W-1:1];
                        cache_valid_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                        rsp_byte_d    = sel_q ? mem_dout[15:8] : mem_dout[7:0];
                        state_d       = S_DONE;
                    end else if (cnt_q == TIMEOUT_C) begin
                        if (rty_q < RETRIES_C) begin
                            mem_rd_d = 1'b1;
                            cnt_d    = '0;
                            rty_d    = rty_q + 1'b1;
                        end else begin
                            rsp_valid_d   = 1'b1;
                            rsp_err_d     = 1'b1;
                            rsp_byte_d    = 8'h80;
                            cache_valid_d = 1'b0;
                            state_d       = S_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!req) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rty_q         <= '0;
            sel_q         <= 1'b0;
            cache_valid_q <= 1'b0;
            tag_q         <= '0;
            word_q        <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_byte_q    <= 8'h00;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rty_q         <= rty_d;
            sel_q         <= sel_d;
            cache_valid_q <= cache_valid_d;
            tag_q         <= tag_d;
            word_q        <= word_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_byte_q    <= rsp_byte_d;
            mem_rd_q      <= mem_rd_d;
            mem_addr_q    <= mem_addr_d;
            busy_q        <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_byte  = rsp_byte_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
